io_bridge: RTL
==============

# io_bridge

Memory-mapped I/O bridge that sits directly downstream of the multicycle load/store datapath's `write_out` and upstream of its `read_in`. Processor stores to the output port are buffered in a small FIFO and drained to an external consumer over a valid/ready handshake. External input words are captured into a single holding register with its own valid/ready handshake, then presented on `read_in` until the processor consumes them. A sticky overflow flag is optional.

## Interface
- `DEPTH`, 4: output FIFO entries; must be a power of two, ≥2.
- `WIDTH`, 16: data width; must match datapath word width.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_wr_strobe`  in  1  one-cycle pulse: processor store to output port.
- `write_out`  in  WIDTH  store data from datapath, sampled when `cpu_wr_strobe`=1.
- `cpu_rd_strobe`  in  1  one-cycle pulse: processor has consumed `read_in`.
- `read_in`  out  WIDTH  held input word to datapath.
- `in_avail`  out  1  holding register contains an unconsumed word.
- `ext_out_valid`  out  1  FIFO head valid toward external consumer.
- `ext_out_data`  out  WIDTH  FIFO head word.
- `ext_out_ready`  in  1  external consumer accepts head this cycle.
- `ext_in_valid`  in  1  external producer offers a word.
- `ext_in_data`  in  WIDTH  offered word.
- `ext_in_ready`  out  1  bridge can accept an input word.
- `out_full`  out  1  output FIFO holds DEPTH entries.
- `ovf_clear`  in  1  clears sticky overflow (only with IO_BRIDGE_OVF_EN).
- `overflow`  out  1  sticky: a store was dropped because FIFO was full.

## Operation
- Output FIFO: circular buffer, write pointer, read pointer (log2(DEPTH) bits, natural wrap), count (log2(DEPTH)+1 bits).
- Push: `cpu_wr_strobe` && (!full || pop this cycle) → store `write_out` at wr_ptr, wr_ptr+1.
- Pop: `ext_out_valid` && `ext_out_ready` → rd_ptr+1.
- Push+pop same cycle: count unchanged; accepted even when full.
- Push when full with no pop: word dropped, pointers unchanged; overflow set (if enabled).
- `ext_out_valid` = count≠0; `ext_out_data` = mem[rd_ptr]; `out_full` = count==DEPTH.
- Input holding register: two states, EMPTY and HELD.
  - EMPTY: `ext_in_ready`=1; `ext_in_valid` → capture `ext_in_data`, go HELD.
  - HELD: `ext_in_ready`=0; `cpu_rd_strobe` → go EMPTY. Data retained in register after consumption.
  - `cpu_rd_strobe` in EMPTY: ignored.
- `read_in` = holding register; `in_avail` = (state==HELD).

## Timing
- Reset values: pointers, count = 0; `ext_out_valid`=0; `out_full`=0; state EMPTY; `read_in`=0; `in_avail`=0; `ext_in_ready`=1; `overflow`=0.
- Reset mid-operation discards all FIFO contents and any held input; no partial handshake survives.
- No fall-through: word pushed in cycle N is visible on `ext_out_valid`/`ext_out_data` from cycle N+1.
- Pop takes effect at edge; next head visible cycle after.
- Input capture at edge N → `in_avail`=1, `read_in` valid in cycle N+1; `ext_in_ready` low from N+1.
- `cpu_rd_strobe` at edge M → `ext_in_ready`=1 in cycle M+1; earliest next capture edge M+1 (one bubble cycle).
- `ext_out_data` stable while `ext_out_valid`=1 and `ext_out_ready`=0.

## Configuration
- `IO_BRIDGE_OVF_EN` defined: `overflow` sets on a dropped store, holds until `ovf_clear`; set and clear in same cycle → set wins.
- Not defined: `overflow` tied 0, `ovf_clear` ignored, no overflow register synthesized. Drop behaviour unchanged.

## Test plan
- Reset: assert `rst` 2 cycles mid-traffic → all outputs at reset values next cycle, `ext_out_valid`=0, `in_avail`=0.
- Fill/drain: 4 stores 0x1111..0x4444, `ext_out_ready`=0 → `out_full`=1; then ready=1 → drained in order 0x1111,0x2222,0x3333,0x4444, one per cycle.
- Overflow (OVF_EN): full FIFO, store 0x5555, no pop → dropped, `overflow`=1; `ovf_clear` → 0; without macro `overflow` stays 0.
- Full push+pop: full, store 0xAAAA with ready=1 → head popped, 0xAAAA accepted as 4th entry, `out_full` stays 1, no overflow.
- Input handshake: `ext_in_valid` with 0xBEEF → `in_avail`=1, `read_in`=0xBEEF, `ext_in_ready`=0; second word 0xCAFE held off until `cpu_rd_strobe`, captured one cycle after.
- Wrap: 10 store/drain pairs at DEPTH=4 → data order preserved across pointer wrap.

Source files
------------

// File: rtl/io_bridge.sv
// ============================================================================
//  Module   : io_bridge
//  Brief    : Memory-mapped I/O bridge: a store FIFO drained over valid/ready
//             and an input holding register read by the datapath.
//             Optional sticky overflow flag is enabled by IO_BRIDGE_OVF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cpu_wr_strobe,
  input  logic [WIDTH-1:0] write_out,
  input  logic             cpu_rd_strobe,
  output logic [WIDTH-1:0] read_in,
  output logic             in_avail,
  output logic             ext_out_valid,
  output logic [WIDTH-1:0] ext_out_data,
  input  logic             ext_out_ready,
  input  logic             ext_in_valid,
  input  logic [WIDTH-1:0] ext_in_data,
  output logic             ext_in_ready,
  output logic             out_full,
  input  logic             ovf_clear,
  output logic             overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);

  localparam logic [0:0] c_ST_EMPTY = 1'b0;
  localparam logic [0:0] c_ST_HELD  = 1'b1;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0]  count_q, count_d;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full = (count_q == c_FULL_COUNT);
  assign w_pop  = (count_q != '0) && ext_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = cpu_wr_strobe && (!w_full || w_pop);
  assign w_drop = cpu_wr_strobe && w_full && !w_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observable after being written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= write_out;
    end
  end

  assign ext_out_valid = (count_q != '0);
  assign ext_out_data  = mem_q[rd_ptr_q];
  assign out_full      = w_full;

  // ---------------------------------------------------------------------------
  // Input holding register (two-state FSM)
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= c_ST_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      c_ST_EMPTY: begin
        if (ext_in_valid) begin
          state_d = c_ST_HELD;
          hold_d  = ext_in_data;
        end
      end
      c_ST_HELD: begin
        if (cpu_rd_strobe) begin
          state_d = c_ST_EMPTY;
        end
      end
      default: state_d = c_ST_EMPTY;
    endcase
  end

  always_comb begin
    in_avail     = 1'b0;
    ext_in_ready = 1'b0;
    case (state_q)
      c_ST_EMPTY: ext_in_ready = 1'b1;
      c_ST_HELD:  in_avail     = 1'b1;
      default:    ext_in_ready = 1'b0;
    endcase
  end

  assign read_in = hold_q;

  // ---------------------------------------------------------------------------
  // Sticky overflow
  // ---------------------------------------------------------------------------
`ifdef IO_BRIDGE_OVF_EN
  logic overflow_q, overflow_d;

  // Set has priority over clear when both occur in one cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ovf_clear ^ w_drop;
  assign overflow     = 1'b0;
`endif

endmodule

`default_nettype wire
